device_tx: RTL and testbench

- MKIO (GOST 26765.52) remote-terminal transmit path for the RT->BC direction.
- On a decoded transmit command it sends one status word, then N data words read from the device's data memory, through the channel encoder.
- Sits beside the receive-path device, sharing the decoder (rx_data/p_error) and the encoder handshake (tx_data/tx_cd/tx_ready/tx_busy).
- Memory is external, synchronous-read, with fixed read latency.

---
 rtl/mkio_pkg.sv | 31 +++
 rtl/mkio_tx_handshake.sv | 47 ++++
 rtl/device_tx.sv | 163 ++++++++++++++++
 tb/tb_device_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO remote-terminal transmit and receive paths:
// FSM encoding, status-word layout and command word-count decoding.
package mkio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FIN       = 3'd5
  } state_t;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 11;
  localparam int ME_BIT   = 10;

  // A word-count field of zero encodes the maximum message of 32 words.
  function automatic logic [5:0] decode_wcnt(input logic [4:0] field);
    return (field == 5'd0) ? 6'd32 : {1'b0, field};
  endfunction

  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic me);
    logic [15:0] w;
    w                    = '0;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[ME_BIT]            = me;
    return w;
  endfunction

endpackage

// File: rtl/mkio_tx_handshake.sv
// Encoder handshake for one word: request pulse, acknowledge wait with
// timeout, and end-of-serialisation detection. Shared by RT transmit paths.
module mkio_tx_handshake
  import mkio_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic   clk,
  input  logic   reset,
  input  state_t i_state,
  input  logic   i_abort,
  input  logic   i_tx_busy,
  output logic   o_tx_ready,
  output logic   o_acked,
  output logic   o_timeout,
  output logic   o_enc_done
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] r_ack_cnt;
  logic             w_live;
  logic             w_in_ack;
  logic             w_expired;

  // A new command aborts the word in flight, so every strobe is gated by it.
  assign w_live     = !i_abort;
  assign w_in_ack   = (i_state == ST_WAIT_ACK);
  assign w_expired  = (r_ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

  assign o_tx_ready = w_live && (i_state == ST_REQ);
  assign o_acked    = w_live && w_in_ack && i_tx_busy;
  assign o_timeout  = w_live && w_in_ack && !i_tx_busy && w_expired;
  assign o_enc_done = w_live && (i_state == ST_WAIT_DONE) && !i_tx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack_cnt <= '0;
    end else if (w_live && w_in_ack && !i_tx_busy && !w_expired) begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      r_ack_cnt <= r_ack_cnt + CNT_W'(1);
    end else begin
      r_ack_cnt <= '0;
    end
  end

endmodule

// File: rtl/device_tx.sv
// MKIO remote-terminal transmit path: status word followed by N data words
// prefetched from a synchronous-read data memory, fed to the channel encoder.
module device_tx
  import mkio_pkg::*;
#(
  parameter logic [4:0] ADDRESS     = 5'd1,
  parameter int         MEM_LATENCY = 1,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] rx_data,
  input  logic        p_error,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  output logic        tx_ready,
  input  logic        tx_busy,
  output logic [4:0]  mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_q,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  r_word_idx;
  logic        r_me;
  logic [1:0]  r_lat;
  logic [15:0] r_next;
  logic        r_next_vld;

  logic        w_load_status;
  logic        w_load_word;
  logic        w_to_idle;
  logic        w_words_left;
  logic        w_acked;
  logic        w_enc_done;
  logic        w_unused;

  assign w_unused     = ^rx_data[15:5];
  assign w_words_left = (r_word_idx < r_cnt) && !r_me;
  assign busy         = (r_state != ST_IDLE);
  // Index 32 after the last word of a full message wraps the address to 0.
  assign mem_addr     = r_word_idx[4:0];

  mkio_tx_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .i_state   (r_state),
    .i_abort   (start),
    .i_tx_busy (tx_busy),
    .o_tx_ready(tx_ready),
    .o_acked   (w_acked),
    .o_timeout (timeout_err),
    .o_enc_done(w_enc_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_state_nxt   = r_state;
    w_load_status = 1'b0;
    w_load_word   = 1'b0;
    w_to_idle     = 1'b0;
    mem_rd        = 1'b0;
    done          = 1'b0;

    if (start) begin
      w_state_nxt = ST_CAPTURE;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_CAPTURE: begin
          w_load_status = 1'b1;
          w_state_nxt   = ST_REQ;
        end
        ST_REQ: begin
          mem_rd      = w_words_left;
          w_state_nxt = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (w_acked) begin
            w_state_nxt = ST_WAIT_DONE;
          end else if (timeout_err) begin
            w_to_idle   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (w_enc_done) begin
            if (!w_words_left) begin
              w_state_nxt = ST_FIN;
            end else if (r_next_vld) begin
              w_load_word = 1'b1;
              w_state_nxt = ST_REQ;
            end
          end
        end
        ST_FIN: begin
          done        = 1'b1;
          w_to_idle   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_me       <= 1'b0;
      r_lat      <= '0;
      r_next     <= '0;
      r_next_vld <= 1'b0;
      r_word_idx <= '0;
      tx_data    <= '0;
      tx_cd      <= 1'b0;
    end else begin
      if (start) begin
        r_cnt      <= decode_wcnt(rx_data[4:0]);
        r_me       <= p_error;
        r_lat      <= '0;
        r_next_vld <= 1'b0;
      end else begin
        // Read data is taken exactly MEM_LATENCY cycles after its strobe.
        if (mem_rd)            r_lat <= 2'(MEM_LATENCY);
        else if (r_lat != 2'd0) r_lat <= r_lat - 2'd1;

        if (r_lat == 2'd1) begin
          r_next     <= mem_q;
          r_next_vld <= 1'b1;
        end else if (w_load_word) begin
          r_next_vld <= 1'b0;
        end
      end

      if (w_load_status) begin
        tx_data    <= status_word(ADDRESS, r_me);
        tx_cd      <= 1'b1;
        r_word_idx <= '0;
      end else if (w_load_word) begin
        tx_data    <= r_next;
        tx_cd      <= 1'b0;
        r_word_idx <= r_word_idx + 6'd1;
      end else if (w_to_idle) begin
        tx_cd      <= 1'b0;
        r_word_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_device_tx.sv
// Self-checking bench for device_tx: scoreboard of expected encoder words and
// memory addresses, plus directed latency, timeout, supersede and reset checks.
module tb_device_tx;

  logic        clk;
  logic        reset;

  logic        start1, pe1, tx_cd1, tx_ready1, tx_busy1, mem_rd1, busy1, done1, timeout1;
  logic [15:0] rx1, tx_data1, mem_q1;
  logic [4:0]  mem_addr1;

  logic        start3, pe3, tx_cd3, tx_ready3, tx_busy3, mem_rd3, busy3, done3, timeout3;
  logic [15:0] rx3, tx_data3, mem_q3;
  logic [4:0]  mem_addr3;

  logic [15:0] mem1 [32];
  logic [15:0] mem3 [32];
  logic [15:0] m3_pipe [3];

  logic [16:0] exp_tx1 [$];
  logic [16:0] exp_tx3 [$];
  logic [4:0]  exp_addr1 [$];
  logic [4:0]  exp_addr3 [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ready1 = 0, n_rd1 = 0, n_done1 = 0, n_to1 = 0;
  int n_ready3 = 0;
  int last_hi1 = 0, gap1 = 0, ready_cyc1 = 0, to_cyc1 = 0;
  int ready_cyc3 = 0, gap3 = 0;
  int enc1_len = 20, enc1_cnt = 0, enc3_len = 1, enc3_cnt = 0;
  bit enc1_mute = 0;

  device_tx #(.ADDRESS(5'd1), .MEM_LATENCY(1), .ACK_TIMEOUT(64)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rx_data(rx1), .p_error(pe1),
    .tx_data(tx_data1), .tx_cd(tx_cd1), .tx_ready(tx_ready1), .tx_busy(tx_busy1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_q(mem_q1),
    .busy(busy1), .done(done1), .timeout_err(timeout1)
  );

  device_tx #(.ADDRESS(5'd1), .MEM_LATENCY(3), .ACK_TIMEOUT(64)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .rx_data(rx3), .p_error(pe3),
    .tx_data(tx_data3), .tx_cd(tx_cd3), .tx_ready(tx_ready3), .tx_busy(tx_busy3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_q(mem_q3),
    .busy(busy3), .done(done3), .timeout_err(timeout3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) cyc++;

  // Memory models; garbage is returned whenever no read was issued.
  always @(posedge clk) mem_q1 <= mem_rd1 ? mem1[mem_addr1] : 16'hDEAD;
  always @(posedge clk) begin
    m3_pipe[0] <= mem_rd3 ? mem3[mem_addr3] : 16'hBEEF;
    m3_pipe[1] <= m3_pipe[0];
    m3_pipe[2] <= m3_pipe[1];
  end
  assign mem_q3 = m3_pipe[2];

  // Encoder models: busy for enc*_len cycles starting the cycle after tx_ready.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_busy1 <= 1'b0; enc1_cnt <= 0;
    end else if (tx_ready1 && !enc1_mute) begin
      tx_busy1 <= 1'b1; enc1_cnt <= enc1_len;
    end else if (enc1_cnt > 1) begin
      enc1_cnt <= enc1_cnt - 1;
    end else begin
      tx_busy1 <= 1'b0; enc1_cnt <= 0;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_busy3 <= 1'b0; enc3_cnt <= 0;
    end else if (tx_ready3) begin
      tx_busy3 <= 1'b1; enc3_cnt <= enc3_len;
    end else if (enc3_cnt > 1) begin
      enc3_cnt <= enc3_cnt - 1;
    end else begin
      tx_busy3 <= 1'b0; enc3_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    logic [16:0] e;
    logic [4:0]  a;
    if (reset) begin
      if (tx_busy1) last_hi1 = cyc;
      if (tx_ready1) begin
        n_ready1++;
        gap1       = cyc - last_hi1;
        ready_cyc1 = cyc;
        check("tx1_expected", 32'(exp_tx1.size() != 0), 32'd1);
        if (exp_tx1.size() != 0) begin
          e = exp_tx1.pop_front();
          check("tx1_word", 32'({tx_cd1, tx_data1}), 32'(e));
        end
      end
      if (mem_rd1) begin
        n_rd1++;
        check("rd1_expected", 32'(exp_addr1.size() != 0), 32'd1);
        if (exp_addr1.size() != 0) begin
          a = exp_addr1.pop_front();
          check("rd1_addr", 32'(mem_addr1), 32'(a));
        end
      end
      if (done1) n_done1++;
      if (timeout1) begin
        n_to1++;
        to_cyc1 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    logic [4:0]  a;
    if (reset) begin
      if (tx_ready3) begin
        n_ready3++;
        gap3       = cyc - ready_cyc3;
        ready_cyc3 = cyc;
        check("tx3_expected", 32'(exp_tx3.size() != 0), 32'd1);
        if (exp_tx3.size() != 0) begin
          e = exp_tx3.pop_front();
          check("tx3_word", 32'({tx_cd3, tx_data3}), 32'(e));
        end
      end
      if (mem_rd3) begin
        check("rd3_expected", 32'(exp_addr3.size() != 0), 32'd1);
        if (exp_addr3.size() != 0) begin
          a = exp_addr3.pop_front();
          check("rd3_addr", 32'(mem_addr3), 32'(a));
        end
      end
    end
  end

  // Expected encoder words and reads for one message on dut1 (sel=0) or dut3.
  task automatic push_msg(input bit sel, input logic me, input int n);
    logic [15:0] st;
    st = {5'd1, me, 10'b0};
    if (!sel) exp_tx1.push_back({1'b1, st}); else exp_tx3.push_back({1'b1, st});
    if (!me) begin
      for (int i = 0; i < n; i++) begin
        if (!sel) begin
          exp_tx1.push_back({1'b0, mem1[i]});
          exp_addr1.push_back(5'(i));
        end else begin
          exp_tx3.push_back({1'b0, mem3[i]});
          exp_addr3.push_back(5'(i));
        end
      end
    end
  endtask

  task automatic start1_pulse(input logic [15:0] rx, input logic pe);
    @(posedge clk); #1;
    start1 = 1'b1; rx1 = rx; pe1 = pe;
    @(posedge clk); #1;
    start1 = 1'b0; rx1 = 16'h0; pe1 = 1'b0;
  endtask

  task automatic start3_pulse(input logic [15:0] rx);
    @(posedge clk); #1;
    start3 = 1'b1; rx3 = rx;
    @(posedge clk); #1;
    start3 = 1'b0; rx3 = 16'h0;
  endtask

  task automatic wait_done1(input string tag, input int budget);
    for (int i = 0; i < budget && !done1; i++) @(negedge clk);
    check(tag, 32'(done1), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int r0, d0, t0, seen;
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 16'(32'hC3A5 ^ (i * 32'h1357));
      mem3[i] = 16'(32'h5A3C + (i * 32'h0F11));
    end
    reset = 1'b0;
    start1 = 1'b0; rx1 = 16'h0; pe1 = 1'b0;
    start3 = 1'b0; rx3 = 16'h0; pe3 = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_outs1", {tx_data1, tx_cd1, tx_ready1, mem_addr1, mem_rd1, busy1, done1, timeout1}, 32'd0);
    check("reset_outs3", {tx_data3, tx_cd3, tx_ready3, mem_addr3, mem_rd3, busy3, done3, timeout3}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Three-word message, 20-cycle encoder busy.
    r0 = n_ready1; d0 = n_done1; t0 = n_rd1;
    push_msg(0, 1'b0, 3);
    start1_pulse(16'h0003, 1'b0);
    @(negedge clk);
    check("t1_capture_no_ready", 32'(tx_ready1), 32'd0);
    check("t1_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    check("t1_start_to_ready", 32'(tx_ready1), 32'd1);
    wait_done1("t1_done", 200);
    check("t1_busy_low", 32'(busy1), 32'd0);
    check("t1_ready_count", 32'(n_ready1 - r0), 32'd4);
    check("t1_rd_count", 32'(n_rd1 - t0), 32'd3);
    check("t1_done_count", 32'(n_done1 - d0), 32'd1);
    check("t1_busy_fall_gap", 32'(gap1), 32'd2);

    // Word count 0 means 32 data words.
    enc1_len = 4;
    r0 = n_ready1; t0 = n_rd1;
    push_msg(0, 1'b0, 32);
    start1_pulse(16'h0000, 1'b0);
    wait_done1("t2_done", 600);
    check("t2_ready_count", 32'(n_ready1 - r0), 32'd33);
    check("t2_rd_count", 32'(n_rd1 - t0), 32'd32);
    check("t2_idle_addr", 32'(mem_addr1), 32'd0);

    // Message error: status word only, no reads.
    r0 = n_ready1; t0 = n_rd1;
    push_msg(0, 1'b1, 5);
    start1_pulse(16'h0005, 1'b1);
    wait_done1("t3_done", 100);
    check("t3_ready_count", 32'(n_ready1 - r0), 32'd1);
    check("t3_rd_count", 32'(n_rd1 - t0), 32'd0);

    // Encoder never acknowledges.
    enc1_mute = 1'b1;
    d0 = n_done1; t0 = n_to1;
    exp_tx1.push_back({1'b1, 16'h0800});
    exp_addr1.push_back(5'd0);
    start1_pulse(16'h0002, 1'b0);
    for (int i = 0; i < 150 && !timeout1; i++) @(negedge clk);
    check("t4_timeout_seen", 32'(timeout1), 32'd1);
    @(negedge clk);
    check("t4_timeout_latency", 32'(to_cyc1 - ready_cyc1), 32'd64);
    check("t4_timeout_count", 32'(n_to1 - t0), 32'd1);
    check("t4_no_done", 32'(n_done1 - d0), 32'd0);
    check("t4_idle_outs", {tx_cd1, tx_ready1, mem_addr1, mem_rd1, busy1, done1, timeout1}, 32'd0);
    check("t4_tx_data_held", 32'(tx_data1), 32'h0800);
    enc1_mute = 1'b0;
    enc1_len  = 20;
    repeat (3) @(negedge clk);

    // Supersede during the second data word.
    r0 = n_ready1; d0 = n_done1;
    exp_tx1.push_back({1'b1, 16'h0800});
    exp_tx1.push_back({1'b0, mem1[0]});
    exp_addr1.push_back(5'd0);
    exp_addr1.push_back(5'd1);
    push_msg(0, 1'b0, 2);
    start1_pulse(16'h0003, 1'b0);
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge clk);
      if (tx_ready1) seen++;
    end
    check("t5_first_words", 32'(seen), 32'd2);
    repeat (22) @(posedge clk);
    #1;
    start1 = 1'b1; rx1 = 16'h0002;
    @(negedge clk);
    check("t5_ready_blocked", 32'({tx_ready1, mem_rd1}), 32'd0);
    @(posedge clk); #1;
    start1 = 1'b0; rx1 = 16'h0;
    @(negedge clk);
    check("t5_capture_no_ready", 32'(tx_ready1), 32'd0);
    @(negedge clk);
    check("t5_new_status_ready", 32'(tx_ready1), 32'd1);
    wait_done1("t5_done", 200);
    check("t5_ready_count", 32'(n_ready1 - r0), 32'd5);
    check("t5_done_count", 32'(n_done1 - d0), 32'd1);

    // Latency-3 memory with one-cycle encoder busy: stalls in WAIT_DONE.
    push_msg(1, 1'b0, 2);
    start3_pulse(16'h0002);
    for (int i = 0; i < 100 && !done3; i++) @(negedge clk);
    check("t6_done", 32'(done3), 32'd1);
    @(negedge clk);
    check("t6_stall_gap", 32'(gap3), 32'd5);
    check("t6_busy_low", 32'(busy3), 32'd0);

    // Asynchronous reset in the middle of a message.
    push_msg(1, 1'b0, 5);
    start3_pulse(16'h0005);
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge clk);
      if (tx_ready3) seen++;
    end
    check("t6_mid_words", 32'(seen), 32'd2);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("t6_async_rst3", {tx_data3, tx_cd3, tx_ready3, mem_addr3, mem_rd3, busy3, done3, timeout3}, 32'd0);
    check("t6_async_rst1", {tx_data1, tx_cd1, tx_ready1, mem_addr1, mem_rd1, busy1, done1, timeout1}, 32'd0);
    exp_tx3.delete();
    exp_addr3.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("q_tx1_empty", 32'(exp_tx1.size()), 32'd0);
    check("q_addr1_empty", 32'(exp_addr1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
